// File: rtl/instr_encoder.sv
// Field-level instruction encoder: packs requests into 16-bit ISA words, tags each with its
// target address and streams {word,addr} through a 2-entry buffer to the memory writer.
module instr_encoder #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [3:0]            in_dr,
  input  logic [3:0]            in_sr1,
  input  logic [3:0]            in_sr2,
  input  logic [7:0]            in_imm,
  input  logic                  in_shl,
  input  logic                  in_sha,
  input  logic [3:0]            in_nzci,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_word,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ADDR_WIDTH-1:0] instr_count,
  output logic                  err_valid,
  output logic [1:0]            err_code
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_AND = 4'h3,
    OP_OR   = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_SH  = 4'h7,
    OP_LD   = 4'h8, OP_ST  = 4'h9, OP_LDI = 4'hA, OP_B   = 4'hB,
    OP_ADDI = 4'hC, OP_AIPC = 4'hD
  } opcode_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;

  logic [15:0]           word_next;
  logic [1:0]            err_next;
  logic                  simm4_ok;
  logic                  full;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic [ADDR_WIDTH-1:0] addr_ctr_reg;
  logic [ADDR_WIDTH-1:0] instr_count_reg;
  logic                  err_valid_reg;
  logic [1:0]            err_code_reg;
  logic [15:0]           slot_word [2];
  logic [ADDR_WIDTH-1:0] slot_addr [2];

  // A 4-bit signed immediate fits iff the upper five bits are a pure sign extension.
  assign simm4_ok = (in_imm[7:3] == 5'b00000) || (in_imm[7:3] == 5'b11111);

  always_comb begin
    word_next = {in_op, 12'h000};
    err_next  = ERR_NONE;
    case (in_op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR:
        word_next = {in_op, in_dr, in_sr1, in_sr2};
      OP_NOT:
        word_next = {in_op, in_dr, in_sr1, 4'h0};
      OP_SH: begin
        word_next = {in_op, in_dr, in_shl, in_sha, 1'b0, in_imm[4:0]};
        if (in_imm[7:5] != 3'b000) err_next = ERR_RANGE;
      end
      OP_LD, OP_ST, OP_ADDI: begin
        word_next = {in_op, in_dr, in_sr1, in_imm[3:0]};
        if (!simm4_ok) err_next = ERR_RANGE;
      end
      OP_LDI, OP_AIPC:
        word_next = {in_op, in_dr, in_imm};
      OP_B:
        word_next = {in_op, in_nzci, in_imm};
      default:
        err_next = ERR_OPCODE;
    endcase
  end

  // Ready depends only on registered occupancy plus the rst/start overrides.
  assign full      = (count_reg == 2'd2);
  assign in_ready  = !rst && !start && !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (err_next == ERR_NONE);
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [15:0]           word_reg;
      logic [ADDR_WIDTH-1:0] tag_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          word_reg <= word_next;
          tag_reg  <= addr_ctr_reg;
        end
      end
      assign slot_word[gi] = word_reg;
      assign slot_addr[gi] = tag_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
      addr_ctr_reg    <= '0;
      instr_count_reg <= '0;
      err_valid_reg   <= 1'b0;
      err_code_reg    <= ERR_NONE;
    end else begin
      err_valid_reg <= 1'b0;
      if (start) begin
        wr_ptr_reg      <= 1'b0;
        rd_ptr_reg      <= 1'b0;
        count_reg       <= 2'd0;
        addr_ctr_reg    <= start_addr;
        instr_count_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        if (push) begin
          addr_ctr_reg    <= addr_ctr_reg + 1'b1;
          instr_count_reg <= instr_count_reg + 1'b1;
        end
        if (accept && (err_next != ERR_NONE)) begin
          err_valid_reg <= 1'b1;
          err_code_reg  <= err_next;
        end
      end
    end
  end

  assign out_word    = slot_word[rd_ptr_reg];
  assign out_addr    = slot_addr[rd_ptr_reg];
  assign instr_count = instr_count_reg;
  assign err_valid   = err_valid_reg;
  assign err_code    = err_code_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed spec vectors plus randomized traffic against an
// arithmetic encoding model with a queue-based buffer/address scoreboard.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, in_shl, in_sha, out_valid, out_ready, err_valid;
  logic [15:0] start_addr, out_addr, instr_count, out_word;
  logic [3:0]  in_op, in_dr, in_sr1, in_sr2, in_nzci;
  logic [7:0]  in_imm;
  logic [1:0]  err_code;

  int n_cmp = 0, n_bad = 0, err_exp = 0, err_seen = 0;
  logic [31:0] exp_q [$];
  logic [32:0] got_q [$], expd_q [$];
  logic [15:0] m_addr = 16'h0, m_count = 16'h0;
  logic [1:0]  m_err_code = 2'b00;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dr(in_dr),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_imm(in_imm), .in_shl(in_shl),
    .in_sha(in_sha), .in_nzci(in_nzci), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .instr_count(instr_count),
    .err_valid(err_valid), .err_code(err_code)
  );

  // Reference encoding from the field rules; returns 0 ok, 1 illegal opcode, 2 out of range.
  function automatic int ref_encode(input logic [3:0] op, dr, sr1, sr2, input logic [7:0] imm,
                                    input logic shl, sha, input logic [3:0] nzci,
                                    output logic [15:0] w);
    int o, d, s1, u, s, x;
    o = int'(op); d = int'(dr); s1 = int'(sr1); u = int'(imm); s = int'($signed(imm)); x = 0;
    w = 16'h0;
    if (o >= 14) return 1;
    case (o)
      0, 1, 2, 3, 4, 5: x = o*4096 + d*256 + s1*16 + int'(sr2);
      6: x = o*4096 + d*256 + s1*16;
      7: begin
        if (u > 31) return 2;
        x = o*4096 + d*256 + int'(shl)*128 + int'(sha)*64 + u;
      end
      8, 9, 12: begin
        if (s < -8 || s > 7) return 2;
        x = o*4096 + d*256 + s1*16 + (s & 15);
      end
      10, 13: x = o*4096 + d*256 + u;
      default: x = o*4096 + int'(nzci)*256 + u;
    endcase
    w = x[15:0];
    return 0;
  endfunction

  // One clock: records handshakes, then advances the model; ends on the falling edge.
  task automatic tick(output bit acc);
    bit pop; int e; logic [15:0] w;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      got_q.push_back({1'b0, out_word, out_addr});
      if (exp_q.size() > 0) expd_q.push_back({1'b0, exp_q.pop_front()});
      else expd_q.push_back(33'h1_0000_0000);
    end
    e = 0; w = 16'h0;
    if (acc) e = ref_encode(in_op, in_dr, in_sr1, in_sr2, in_imm, in_shl, in_sha, in_nzci, w);
    @(posedge clk);
    if (rst) begin
      exp_q.delete(); m_addr = 16'h0; m_count = 16'h0; m_err_code = 2'b00;
    end else if (start) begin
      exp_q.delete(); m_addr = start_addr; m_count = 16'h0;
    end else if (acc) begin
      if (e == 0) begin
        exp_q.push_back({w, m_addr}); m_addr = m_addr + 1'b1; m_count = m_count + 1'b1;
      end else begin
        m_err_code = 2'(e); err_exp++;
      end
    end
    @(negedge clk);
    if (err_valid) err_seen++;
  endtask

  task automatic set_req(input logic [3:0] op, dr, sr1, sr2, input logic [7:0] imm,
                         input logic shl, sha, input logic [3:0] nzci);
    in_op = op; in_dr = dr; in_sr1 = sr1; in_sr2 = sr2; in_imm = imm;
    in_shl = shl; in_sha = sha; in_nzci = nzci;
  endtask

  task automatic send(input logic [3:0] op, dr, sr1, sr2, input logic [7:0] imm,
                      input logic shl, sha, input logic [3:0] nzci);
    bit ok = 1'b0;
    set_req(op, dr, sr1, sr2, imm, shl, sha, nzci);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) tick(ok);
    in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL send_accept: got no accept in 20 cycles, required accept"); end
  endtask

  task automatic test_reset();
    bit a;
    rst = 1'b1; start = 1'b0; start_addr = 16'h0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(4'h0, 4'h0, 4'h0, 4'h0, 8'h0, 1'b0, 1'b0, 4'h0);
    tick(a); tick(a);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (instr_count !== 16'h0) begin n_bad++; $display("FAIL rst_count: got %h required 0000", instr_count); end
    n_cmp++; if ({err_valid, err_code} !== 3'b000) begin n_bad++; $display("FAIL rst_err: got %b required 000", {err_valid, err_code}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [3:0]  t_op [6]  = '{4'h0, 4'hC, 4'hB, 4'h7, 4'h6, 4'hA};
    logic [3:0]  t_dr [6]  = '{4'h3, 4'h1, 4'h0, 4'h2, 4'h1, 4'h5};
    logic [3:0]  t_s1 [6]  = '{4'h4, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0};
    logic [3:0]  t_s2 [6]  = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0};
    logic [7:0]  t_imm [6] = '{8'h00, 8'hFF, 8'hFE, 8'h03, 8'h00, 8'h80};
    logic        t_shl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  t_nz [6]  = '{4'hF, 4'hF, 4'hA, 4'hF, 4'hF, 4'hF};
    logic [15:0] t_w [6]   = '{16'h0345, 16'hC12F, 16'hBAFE, 16'h7283, 16'h6120, 16'hA580};
    bit a;
    start_addr = 16'h0100; start = 1'b1; tick(a); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(t_op[i], t_dr[i], t_s1[i], t_s2[i], t_imm[i], t_shl[i], 1'b0, t_nz[i]);
      n_cmp++;
      if ({out_valid, out_word, out_addr, instr_count} !== {1'b1, t_w[i], 16'h0100 + 16'(i), 16'(i + 1)}) begin
        n_bad++;
        $display("FAIL directed_%0d: got v=%b w=%h a=%h n=%h required v=1 w=%h a=%h n=%h", i, out_valid,
                 out_word, out_addr, instr_count, t_w[i], 16'h0100 + 16'(i), 16'(i + 1));
      end
      out_ready = 1'b1; tick(a); out_ready = 1'b0;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL directed_drained: got %b required 0", out_valid); end
  endtask

  task automatic test_errors();
    logic [3:0] e_op [6]   = '{4'hE, 4'hF, 4'hC, 4'hE, 4'h9, 4'h7};
    logic [7:0] e_imm [6]  = '{8'h00, 8'h08, 8'h08, 8'hFF, 8'hF7, 8'h20};
    logic [1:0] e_code [6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    bit a;
    for (int i = 0; i < 6; i++) begin
      send(e_op[i], 4'h1, 4'h2, 4'h3, e_imm[i], 1'b0, 1'b0, 4'h0);
      n_cmp++;
      if ({err_valid, err_code, out_valid, instr_count} !== {1'b1, e_code[i], 1'b0, 16'h0006}) begin
        n_bad++;
        $display("FAIL err_%0d: got ev=%b ec=%b ov=%b n=%h required ev=1 ec=%b ov=0 n=0006", i,
                 err_valid, err_code, out_valid, instr_count, e_code[i]);
      end
      tick(a);
      n_cmp++;
      if ({err_valid, err_code} !== {1'b0, e_code[i]}) begin
        n_bad++; $display("FAIL err_hold_%0d: got ev=%b ec=%b required ev=0 ec=%b", i, err_valid, err_code, e_code[i]);
      end
    end
    send(4'hC, 4'h1, 4'h2, 4'h0, 8'hF8, 1'b0, 1'b0, 4'h0);
    n_cmp++;
    if ({out_word, out_addr, err_valid, err_code} !== {16'hC128, 16'h0106, 1'b0, 2'b10}) begin
      n_bad++; $display("FAIL addi_min: got w=%h a=%h ev=%b ec=%b required w=C128 a=0106 ev=0 ec=10",
                        out_word, out_addr, err_valid, err_code);
    end
    out_ready = 1'b1; tick(a); out_ready = 1'b0;
    send(4'h7, 4'h0, 4'h0, 4'h0, 8'h1F, 1'b0, 1'b1, 4'h0);
    n_cmp++;
    if ({out_word, out_addr, instr_count} !== {16'h705F, 16'h0107, 16'h0008}) begin
      n_bad++; $display("FAIL sh_max: got w=%h a=%h n=%h required w=705F a=0107 n=0008", out_word, out_addr, instr_count);
    end
    out_ready = 1'b1; tick(a); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit a; int acc_n = 0;
    out_ready = 1'b0;
    set_req(4'h0, 4'h1, 4'h2, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0);
    in_valid = 1'b1;
    tick(a); acc_n += int'(a);
    tick(a); acc_n += int'(a);
    n_cmp++; if (acc_n != 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d required 2", acc_n); end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({in_ready, out_word, out_addr} !== {1'b0, 16'h0123, 16'h0108}) begin
        n_bad++; $display("FAIL b2b_stall_%0d: got rdy=%b w=%h a=%h required rdy=0 w=0123 a=0108", i, in_ready, out_word, out_addr);
      end
      tick(a);
    end
    out_ready = 1'b1; tick(a); out_ready = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_addr} !== {1'b1, 16'h0109}) begin
      n_bad++; $display("FAIL b2b_freed: got rdy=%b a=%h required rdy=1 a=0109", in_ready, out_addr);
    end
    tick(a); in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({a, in_ready, instr_count} !== {1'b1, 1'b0, 16'h000B}) begin
      n_bad++; $display("FAIL b2b_third: got acc=%b rdy=%b n=%h required acc=1 rdy=0 n=000B", a, in_ready, instr_count);
    end
    out_ready = 1'b1; tick(a); tick(a); out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit a;
    start_addr = 16'hFFFF; start = 1'b1; tick(a); start = 1'b0;
    send(4'h0, 4'h1, 4'h1, 4'h1, 8'h00, 1'b0, 1'b0, 4'h0);
    send(4'h0, 4'h2, 4'h2, 4'h2, 8'h00, 1'b0, 1'b0, 4'h0);
    n_cmp++;
    if ({out_word, out_addr} !== {16'h0111, 16'hFFFF}) begin
      n_bad++; $display("FAIL wrap_first: got w=%h a=%h required w=0111 a=FFFF", out_word, out_addr);
    end
    out_ready = 1'b1; tick(a); out_ready = 1'b0;
    n_cmp++;
    if ({out_word, out_addr, instr_count} !== {16'h0222, 16'h0000, 16'h0002}) begin
      n_bad++; $display("FAIL wrap_second: got w=%h a=%h n=%h required w=0222 a=0000 n=0002", out_word, out_addr, instr_count);
    end
    out_ready = 1'b1; tick(a); out_ready = 1'b0;
  endtask

  task automatic test_start_flush();
    bit a;
    start_addr = 16'h0200; start = 1'b1; tick(a); start = 1'b0;
    send(4'h1, 4'h1, 4'h1, 4'h1, 8'h00, 1'b0, 1'b0, 4'h0);
    send(4'h1, 4'h2, 4'h2, 4'h2, 8'h00, 1'b0, 1'b0, 4'h0);
    start_addr = 16'h0300; start = 1'b1; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL start_ready: got %b required 0", in_ready); end
    tick(a); start = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, instr_count, err_code} !== {1'b0, 16'h0000, 2'b10}) begin
      n_bad++; $display("FAIL start_flush: got ov=%b n=%h ec=%b required ov=0 n=0000 ec=10", out_valid, instr_count, err_code);
    end
    send(4'h2, 4'h4, 4'h5, 4'h6, 8'h00, 1'b0, 1'b0, 4'h0);
    n_cmp++;
    if ({out_word, out_addr, instr_count} !== {16'h2456, 16'h0300, 16'h0001}) begin
      n_bad++; $display("FAIL start_reload: got w=%h a=%h n=%h required w=2456 a=0300 n=0001", out_word, out_addr, instr_count);
    end
    out_ready = 1'b1; tick(a); out_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    bit a;
    send(4'h3, 4'h1, 4'h1, 4'h1, 8'h00, 1'b0, 1'b0, 4'h0);
    send(4'h4, 4'h2, 4'h2, 4'h2, 8'h00, 1'b0, 1'b0, 4'h0);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b required 0", in_ready); end
    tick(a);
    n_cmp++;
    if ({out_valid, instr_count, err_code} !== {1'b0, 16'h0000, 2'b00}) begin
      n_bad++; $display("FAIL midrst_state: got ov=%b n=%h ec=%b required ov=0 n=0000 ec=00", out_valid, instr_count, err_code);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_release: got %b required 1", in_ready); end
  endtask

  task automatic test_random();
    bit a, exp_rdy;
    start_addr = 16'($urandom); start = 1'b1; tick(a); start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      start     = ($urandom_range(0, 49) == 0);
      if (start) start_addr = 16'($urandom);
      set_req(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20)) - 8'd10,
              1'($urandom), 1'($urandom), 4'($urandom));
      #1;
      exp_rdy = !start && (exp_q.size() < 2);
      n_cmp++;
      if ({in_ready, out_valid, instr_count, err_code} !== {exp_rdy, exp_q.size() != 0, m_count, m_err_code}) begin
        n_bad++; $display("FAIL rand_ctl_%0d: got rdy=%b ov=%b n=%h ec=%b required rdy=%b ov=%b n=%h ec=%b", c,
                          in_ready, out_valid, instr_count, err_code, exp_rdy, exp_q.size() != 0, m_count, m_err_code);
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({out_word, out_addr} !== exp_q[0]) begin
          n_bad++; $display("FAIL rand_head_%0d: got w=%h a=%h required w=%h a=%h", c, out_word, out_addr,
                            exp_q[0][31:16], exp_q[0][15:0]);
        end
      end
      tick(a);
    end
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_scoreboard();
    bit a;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick(a);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sb_drained: got %b required 0", out_valid); end
    n_cmp++; if (err_seen != err_exp) begin n_bad++; $display("FAIL sb_err_pulses: got %0d required %0d", err_seen, err_exp); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== expd_q[i]) begin
        n_bad++; $display("FAIL sb_pop_%0d: got %h required %h", i, got_q[i], expd_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_wrap();
    test_start_flush();
    test_rst_mid();
    test_random();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
